// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, MDU results queue in a FIFO
// and drain in idle slots or a forced stall slot. Optional pending-write lookup: RF_ARB_PEND_CHECK_EN.
module rf_wr_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  output logic        stall_o,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        RFWr,
  output logic [4:0]  A3,
  output logic [31:0] WD
`ifdef RF_ARB_PEND_CHECK_EN
  ,
  input  logic [4:0]  chk_a1,
  input  logic [4:0]  chk_a2,
  output logic        pend_hit1,
  output logic        pend_hit2
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);

  typedef enum logic [0:0] {ARB, FORCE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  count_q;
  logic [4:0]        mem_rd   [FIFO_DEPTH];
  logic [31:0]       mem_data [FIFO_DEPTH];

  logic        fifo_empty, fifo_full, push, pop, grant;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;

  // Occupancy is the registered count only, so a same-cycle pop never frees a slot
  // and a same-cycle push is never visible to the arbiter (no fall-through).
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == OCC_FULL);
  assign mdu_ready  = !fifo_full;
  assign push       = mdu_valid && mdu_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + CNT_W'(1);
    wb_ready   = 1'b1;
    stall_o    = 1'b0;
    grant      = 1'b0;
    pop        = 1'b0;
    grant_rd   = wb_rd;
    grant_data = wb_data;
    case (state_q)
      ARB: begin
        if (wb_valid) begin
          grant = 1'b1;
          if (!fifo_empty) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = FORCE;
              cnt_d   = '0;
            end
          end
        end else if (!fifo_empty) begin
          grant      = 1'b1;
          pop        = 1'b1;
          grant_rd   = mem_rd[rd_ptr_q];
          grant_data = mem_data[rd_ptr_q];
          cnt_d      = '0;
        end
      end
      FORCE: begin
        stall_o  = 1'b1;
        wb_ready = 1'b0;
        if (!fifo_empty) begin
          grant      = 1'b1;
          pop        = 1'b1;
          grant_rd   = mem_rd[rd_ptr_q];
          grant_data = mem_data[rd_ptr_q];
        end
        cnt_d   = '0;
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr_q]   <= mdu_rd;
      mem_data[wr_ptr_q] <= mdu_data;
    end
  end

  // A grant to rd 0 consumes the slot but never asserts the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RFWr <= 1'b0;
      A3   <= '0;
      WD   <= '0;
    end else begin
      RFWr <= grant && (grant_rd != 5'd0);
      if (grant) begin
        A3 <= grant_rd;
        WD <= grant_data;
      end
    end
  end

`ifdef RF_ARB_PEND_CHECK_EN
  logic [PTR_W-1:0] off;
  logic             entry_valid;

  always_comb begin
    pend_hit1   = RFWr && (A3 == chk_a1);
    pend_hit2   = RFWr && (A3 == chk_a2);
    off         = '0;
    entry_valid = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off         = PTR_W'(i) - rd_ptr_q;
      entry_valid = ({1'b0, off} < count_q);
      if (entry_valid && (mem_rd[i] == chk_a1)) pend_hit1 = 1'b1;
      if (entry_valid && (mem_rd[i] == chk_a2)) pend_hit2 = 1'b1;
    end
    if (chk_a1 == 5'd0) pend_hit1 = 1'b0;
    if (chk_a2 == 5'd0) pend_hit2 = 1'b0;
  end
`endif

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port (RFWr/A3/WD) between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- Pipeline writeback has priority. MDU results are buffered in a small FIFO and drained in idle writeback slots.
- A starvation counter forces a one-cycle pipeline stall so the MDU is guaranteed forward progress.
- Sits between the WB stage, the MDU and the register file.

Parameters:
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- MAX_WAIT, 4, consecutive cycles the MDU head may lose arbitration before a forced grant (≥1)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  WB stage has a register write this cycle
- wb_rd  in  5  WB destination register
- wb_data  in  32  WB write data
- wb_ready  out  1  WB write accepted this cycle
- stall_o  out  1  pipeline stall request (forced MDU slot)
- mdu_valid  in  1  MDU result available
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  FIFO can accept (push when mdu_valid & mdu_ready)
- RFWr  out  1  register file write enable
- A3  out  5  register file write address
- WD  out  32  register file write data

Behaviour:
- Reset: RFWr=0, A3=0, WD=0, stall_o=0, FIFO empty, counter=0, state=ARB. mdu_ready=1, wb_ready=1 immediately after reset.
- FIFO push:
  - mdu_ready = !full, derived from registered occupancy only; a pop in the same cycle does not raise mdu_ready.
  - Push on mdu_valid & mdu_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states ARB, FORCE.
- ARB:
  - wb_ready=1, stall_o=0.
  - If wb_valid: grant WB. If FIFO is non-empty, counter++.
  - Else if FIFO non-empty: grant head, pop, counter=0.
  - If counter reaches MAX_WAIT in this cycle: next state FORCE, counter=0.
- FORCE:
  - stall_o=1, wb_ready=0; grant head, pop; next state ARB.
  - WB stage holds wb_valid/wb_rd/wb_data unchanged while stalled.
- Latency: write-port outputs are registered. A grant in cycle N produces RFWr/A3/WD in cycle N+1; the register file commits at the end of N+1.
- No grant in a cycle: RFWr=0 next cycle; A3/WD hold their previous values.
- rd==0:
  - A request with rd==0 is still granted/popped (consumes the slot) but produces RFWr=0.
  - An MDU entry with rd==0 is still pushed.
- Simultaneous push into an empty FIFO and WB request: the entry cannot be popped the same cycle (fall-through not allowed); earliest drain is the next cycle.
- Ordering: WB and MDU writes to the same rd are committed in grant order. Hazard/RAW avoidance is the hazard unit's job, not this block's.
- Reset mid-operation clears the FIFO contents, counter and FSM; buffered MDU results are discarded.

Optional Feature:
- Macro RF_ARB_PEND_CHECK_EN.
- When defined, add:
  - inputs chk_a1, chk_a2 (5 bits each);
  - outputs pend_hit1, pend_hit2 (1 bit each).
- pend_hitN=1 (combinational) when chk_aN≠0 and matches rd of any valid FIFO entry, or of a write currently registered on A3 with RFWr=1. The hazard unit uses this to stall readers of pending MDU results.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- rst=1 then release, wb_valid=1, wb_rd=5, wb_data=0x1234 for one cycle -> next cycle RFWr=1, A3=5, WD=0x1234; stall_o=0.
- mdu_valid=1, rd=7, data=0xA5A5 with wb_valid=0 -> pushed; popped the following cycle; RFWr=1, A3=7, WD=0xA5A5 one cycle after the pop.
- FIFO holds one entry, wb_valid=1 continuously (MAX_WAIT=4) -> after 4 WB grants, FORCE: stall_o=1, wb_ready=0 for exactly one cycle. The MDU entry is written, then WB resumes and the held WB write commits.
- Push two MDU results while wb_valid=1 -> mdu_ready=0. A third mdu_valid is not accepted until a pop occurs; no entry lost or duplicated.
- wb_valid=1, wb_rd=0, wb_data=0xFFFF -> wb_ready=1, next cycle RFWr=0.
- Assert rst while the FIFO holds 2 entries and state=FORCE -> all outputs return to reset values immediately, the FIFO is empty after release, and no write occurs.
